// File: rtl/data_in_gather_if.sv
// rtl/data_in_gather_if.sv - word gatherer handshake/data bundle; PAR present only with DATA_IN_PAR_EN
interface data_in_gather_if #(
  parameter int DW  = 32,
  parameter int NCH = 8,
  localparam int CW = $clog2(NCH)
);
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [DW*NCH-1:0] DI;
  logic [DW-1:0]     SDI;
  logic              flush;
  logic [DW*NCH-1:0] PDO;
  logic              out_valid;
  logic              out_ready;
  logic [CW:0]       level;
`ifdef DATA_IN_PAR_EN
  logic [NCH-1:0]    PAR;
`endif

  modport master (
    output mode, in_valid, DI, SDI, flush, out_ready,
`ifdef DATA_IN_PAR_EN
    input  PAR,
`endif
    input  in_ready, PDO, out_valid, level
  );

  modport slave (
    input  mode, in_valid, DI, SDI, flush, out_ready,
`ifdef DATA_IN_PAR_EN
    output PAR,
`endif
    output in_ready, PDO, out_valid, level
  );
endinterface

// File: rtl/data_in_gather.sv
// rtl/data_in_gather.sv - assembles NCH words of DW bits into one frame, parallel or serial load
// Optional per-word even parity output enabled by DATA_IN_PAR_EN.
module data_in_gather #(
  parameter int DW  = 32,
  parameter int NCH = 8,
  localparam int CW = $clog2(NCH)
) (
  input  logic           CLK,
  input  logic           rst,
  data_in_gather_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  localparam logic [CW:0] NCH_L = (CW+1)'(NCH);
  localparam logic [CW:0] ONE_L = (CW+1)'(1);

  state_t            state_q, state_d;
  logic [DW*NCH-1:0] pdo_q, pdo_d;
  logic [CW:0]       level_q, level_d;
  logic              out_valid_q, out_valid_d;
  logic              mode_q, mode_d;
  logic              accept;
`ifdef DATA_IN_PAR_EN
  logic [NCH-1:0]    par_q, par_d;
`endif

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.PDO       = pdo_q;
  assign bus.out_valid = out_valid_q;
  assign bus.level     = level_q;
  assign accept        = bus.in_valid & (state_q != HOLD);

  always_comb begin
    state_d     = state_q;
    pdo_d       = pdo_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    mode_d      = mode_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d = bus.mode;
          if (!bus.mode) begin
            pdo_d       = bus.DI;
            level_d     = NCH_L;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            pdo_d          = '0;
            pdo_d[0 +: DW] = bus.SDI;
            level_d        = ONE_L;
            state_d        = FILL;
          end
        end
      end
      FILL: begin
        // The incoming word lands first, so a simultaneous flush closes the frame including it.
        if (accept && mode_q) begin
          for (int k = 0; k < NCH; k++) begin
            if (level_q == (CW+1)'(k)) pdo_d[k*DW +: DW] = bus.SDI;
          end
          level_d = level_q + ONE_L;
          if (level_d == NCH_L || bus.flush) begin
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end else if (bus.flush) begin
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          level_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DATA_IN_PAR_EN
  always_comb begin
    par_d = '0;
    for (int k = 0; k < NCH; k++) par_d[k] = ^pdo_d[k*DW +: DW];
  end
  assign bus.PAR = par_q;
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= IDLE;
      pdo_q       <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      mode_q      <= 1'b0;
`ifdef DATA_IN_PAR_EN
      par_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pdo_q       <= pdo_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
`ifdef DATA_IN_PAR_EN
      par_q       <= par_d;
`endif
    end
  end
endmodule

// File: doc/data_in_gather.md
# data_in_gather

Parametrised word gatherer that assembles NCH words of DW bits into one DW*NCH-bit frame on PDO. It accepts all words at once (parallel mode) or one word per cycle (serial mode), with a partial-frame flush. Valid/ready handshakes on both sides let it sit between a word-producing front end and a wide-datapath consumer. It is the generalised successor of the fixed 8×32-bit input stage.

## Interface
Parameters:
- DW, 32, word width in bits (≥1)
- NCH, 8, words per frame (2..16)
- CW, $clog2(NCH), slot index width (derived, not overridden)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = parallel load, 1 = serial load; sampled only in IDLE
- in_valid  in  1  input word(s) valid
- in_ready  out  1  block can accept input
- DI  in  DW*NCH  parallel input, word k at bits [k*DW +: DW]
- SDI  in  DW  serial input word
- flush  in  1  close a partial serial frame
- PDO  out  DW*NCH  assembled frame, word k at bits [k*DW +: DW]
- out_valid  out  1  PDO holds a complete frame
- out_ready  in  1  consumer takes frame
- level  out  CW+1  words stored in current frame (0..NCH)
- PAR  out  NCH  per-word even parity (only with DATA_IN_PAR_EN)

## Operation
- States: IDLE, FILL, HOLD. Reset → IDLE. Reset values: PDO=0, out_valid=0, level=0, PAR=0, latched mode=0. in_ready=1 after reset.
- in_ready = (state != HOLD). Accept = in_valid & in_ready.
- IDLE, mode=0, accept: PDO←DI, level←NCH → HOLD.
- IDLE, mode=1, accept: PDO word 0←SDI, all other words←0, level←1 → FILL. For NCH=1 this is not allowed, since NCH≥2.
- IDLE, no accept: stays; PDO retains the last delivered frame; flush is ignored.
- FILL, accept: word[level]←SDI, level+1. When the new level equals NCH → HOLD.
- FILL, flush with no accept: remaining words stay zero → HOLD. level keeps its partial count.
- FILL, flush and accept in the same cycle: the word is stored first, then → HOLD with level+1.
- Mode is latched on entry to FILL. A mode change during FILL or HOLD has no effect until the next IDLE.
- HOLD: out_valid=1 and PDO/level are stable. When out_ready=1, the frame is taken → IDLE, out_valid←0, level←0. in_valid is ignored in HOLD; there is no overwrite.
- out_ready while not in HOLD is ignored.
- rst during any state, including mid-FILL or HOLD, discards the frame and restores all reset values on the next edge.

## Timing
- All outputs are registered except in_ready, which is decoded from state.
- Parallel mode: out_valid rises 1 cycle after accept. Throughput is 1 frame per 2 cycles with out_ready held at 1.
- Serial mode: out_valid rises 1 cycle after the NCH-th accepted word, or 1 cycle after flush.
- The frame leaves on the edge where out_valid & out_ready are both 1. in_ready=1 from the next cycle.
- level updates on the same edge as the data write.

## Configuration
- DATA_IN_PAR_EN defined:
  - PAR[k] = ^word k, registered on the same edges as PDO.
  - Zero-padded words give PAR[k]=0.
  - PAR resets to 0.
- DATA_IN_PAR_EN undefined:
  - PAR port and parity logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst=1 for 5 cycles with in_valid=1 → PDO=0, out_valid=0, level=0, in_ready=1.
- Parallel load (DW=32, NCH=8): mode=0, DI words k=0x1000_0000+k, in_valid pulse →
  - next cycle out_valid=1, level=8, PDO word 7=0x1000_0007.
  - out_ready=1 → IDLE.
- Serial full frame: mode=1, SDI=0xA0..0xA7 on 8 consecutive cycles → out_valid 1 cycle after 0xA7, word k=0xA0+k. in_ready=0 while HOLD.
- Backpressure: full frame in HOLD, out_ready=0 for 10 cycles with in_valid=1 and changing DI → PDO unchanged, in_ready=0. out_ready=1 → out_valid falls next cycle.
- Flush: serial 3 words 0x11,0x22,0x33, then flush together with 0x44 → HOLD, level=4, words 4..7=0.
- Mid-operation reset and mode change: serial 5 words, toggle mode to 0 → still FILL. Assert rst → level=0, PDO=0, IDLE. With DATA_IN_PAR_EN, word 0x0000_0007 → PAR[0]=1.
